// File: rtl/rhd_acq_sequencer.sv
// rtl/rhd_acq_sequencer.sv - RHD acquisition sequencer: calibrate, dummy reads, channel sweep, result de-pipelining
module rhd_acq_sequencer #(
  parameter int NUM_CH      = 32,
  parameter int DIV         = 112,
  parameter int CAL_DUMMIES = 9
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable_i,
  output logic        spi_start_o,
  output logic [31:0] spi_data_in_o,
  input  logic        spi_done_i,
  input  logic [31:0] spi_rx_i,
  output logic        sample_valid_o,
  output logic [15:0] sample_data_o,
  output logic [5:0]  sample_channel_o,
  output logic        frame_start_o,
  output logic        overrun_o,
  output logic        busy_o
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int DW = $clog2(CAL_DUMMIES + 2);

  localparam logic [31:0] CMD_CALIBRATE = 32'h5500_0000;
  localparam logic [31:0] CMD_DUMMY     = 32'hFF00_0000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CAL,
    S_DUMMY,
    S_SWEEP,
    S_DRAIN
  } state_t;

  // One entry per issued command; the RHD returns a result two transactions late.
  typedef struct packed {
    logic       vld;
    logic       conv;
    logic [5:0] ch;
  } tag_t;

  state_t          state_q, state_d;
  logic            en_q;
  logic [CW-1:0]   slot_q, slot_d;
  logic [DW-1:0]   dum_q, dum_d;
  logic [5:0]      ch_q, ch_d;
  logic            out_q, out_d;
  logic            overrun_q, overrun_d;
  logic [31:0]     data_q;
  tag_t [2:0]      tag_q, tag_d;
  logic            sv_q;
  logic [15:0]     sdata_q;
  logic [5:0]      sch_q;
  logic            fs_q;

  logic            issue;
  logic            cmd_conv;
  logic [31:0]     cmd;
  logic            out_eff;
  logic            emit;
  tag_t            new_tag;

  // Low half of the MISO word carries nothing the packetizer needs.
  logic            unused_rx;
  assign unused_rx = ^spi_rx_i[15:0];

  // Next-state, command issue, overrun detection and tag bookkeeping.
  always_comb begin
    state_d   = state_q;
    slot_d    = slot_q;
    dum_d     = dum_q;
    ch_d      = ch_q;
    overrun_d = overrun_q;
    tag_d     = tag_q;
    issue     = 1'b0;
    cmd_conv  = 1'b0;
    cmd       = data_q;
    new_tag   = '0;
    // A done arriving in the same cycle as a due slot frees the slot first.
    out_eff   = out_q & ~spi_done_i;
    emit      = spi_done_i & tag_q[2].vld & tag_q[2].conv;

    case (state_q)
      S_IDLE: begin
        slot_d = '0;
        if (enable_i && !en_q) begin
          state_d   = S_CAL;
          overrun_d = 1'b0;
          ch_d      = '0;
          dum_d     = '0;
        end
      end
      S_CAL, S_DUMMY, S_SWEEP: begin
        if (!enable_i) begin
          state_d = S_DRAIN;
          slot_d  = '0;
        end else begin
          slot_d = (slot_q == CW'(DIV - 1)) ? '0 : slot_q + 1'b1;
          if (slot_q == '0) begin
            if (out_eff) begin
              overrun_d = 1'b1;
            end else begin
              issue = 1'b1;
              case (state_q)
                S_CAL: begin
                  cmd     = CMD_CALIBRATE;
                  state_d = (CAL_DUMMIES == 0) ? S_SWEEP : S_DUMMY;
                end
                S_DUMMY: begin
                  cmd   = CMD_DUMMY;
                  dum_d = dum_q + 1'b1;
                  if (dum_q == DW'(CAL_DUMMIES - 1)) state_d = S_SWEEP;
                end
                default: begin
                  cmd      = {2'b00, ch_q, 24'h000000};
                  cmd_conv = 1'b1;
                  ch_d     = (ch_q == 6'(NUM_CH - 1)) ? 6'd0 : ch_q + 6'd1;
                end
              endcase
            end
          end
        end
      end
      S_DRAIN: begin
        slot_d = '0;
        if (!out_q || spi_done_i) begin
          state_d = S_IDLE;
          tag_d   = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (issue) begin
      new_tag.vld  = 1'b1;
      new_tag.conv = cmd_conv;
      new_tag.ch   = ch_q;
      tag_d        = {tag_q[1:0], new_tag};
    end

    if (issue)           out_d = 1'b1;
    else if (spi_done_i) out_d = 1'b0;
    else                 out_d = out_q;
  end

  // Control state; en_q resets high so a level held across reset is not an edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      en_q      <= 1'b1;
      slot_q    <= '0;
      dum_q     <= '0;
      ch_q      <= '0;
      out_q     <= 1'b0;
      overrun_q <= 1'b0;
      data_q    <= '0;
      tag_q     <= '0;
    end else begin
      state_q   <= state_d;
      en_q      <= enable_i;
      slot_q    <= slot_d;
      dum_q     <= dum_d;
      ch_q      <= ch_d;
      out_q     <= out_d;
      overrun_q <= overrun_d;
      data_q    <= cmd;
      tag_q     <= tag_d;
    end
  end

  // Sample output register: one cycle after the done that carries a conversion result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sv_q    <= 1'b0;
      sdata_q <= '0;
      sch_q   <= '0;
      fs_q    <= 1'b0;
    end else begin
      sv_q <= emit;
      fs_q <= emit && (tag_q[2].ch == 6'd0);
      if (emit) begin
        sdata_q <= spi_rx_i[31:16];
        sch_q   <= tag_q[2].ch;
      end
    end
  end

  assign spi_start_o      = issue;
  assign spi_data_in_o    = cmd;
  assign sample_valid_o   = sv_q;
  assign sample_data_o    = sdata_q;
  assign sample_channel_o = sch_q;
  assign frame_start_o    = fs_q;
  assign overrun_o        = overrun_q;
  assign busy_o           = (state_q != S_IDLE);

endmodule

// File: tb/tb_rhd_acq_sequencer.sv
// tb/tb_rhd_acq_sequencer.sv - randomized self-checking bench for rhd_acq_sequencer
module tb_rhd_acq_sequencer;

  localparam int NUM_CH      = 4;
  localparam int DIV         = 112;
  localparam int CAL_DUMMIES = 9;
  localparam logic [31:0] CMD_CAL   = 32'h5500_0000;
  localparam logic [31:0] CMD_DUMMY = 32'hFF00_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable_i = 1'b0;
  logic        spi_done_i = 1'b0;
  logic [31:0] spi_rx_i = '0;
  logic        spi_start_o;
  logic [31:0] spi_data_in_o;
  logic        sample_valid_o;
  logic [15:0] sample_data_o;
  logic [5:0]  sample_channel_o;
  logic        frame_start_o;
  logic        overrun_o;
  logic        busy_o;

  rhd_acq_sequencer #(.NUM_CH(NUM_CH), .DIV(DIV), .CAL_DUMMIES(CAL_DUMMIES)) dut (
    .clk              (clk),
    .rst              (rst),
    .enable_i         (enable_i),
    .spi_start_o      (spi_start_o),
    .spi_data_in_o    (spi_data_in_o),
    .spi_done_i       (spi_done_i),
    .spi_rx_i         (spi_rx_i),
    .sample_valid_o   (sample_valid_o),
    .sample_data_o    (sample_data_o),
    .sample_channel_o (sample_channel_o),
    .frame_start_o    (frame_start_o),
    .overrun_o        (overrun_o),
    .busy_o           (busy_o)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Behavioural model: session-level view of slots, commands and the n-2 result rule.
  typedef enum {M_IDLE, M_RUN, M_DRAIN} mstate_t;
  mstate_t     m_st;
  int          cyc = 0;
  int          t0, idx, cur_k, done_at, force_lat;
  int          lat_lo, lat_hi;
  bit          pending, m_prev_en, m_ovr, m_sv, m_fs, prev_busy;
  logic [15:0] m_sdata;
  logic [5:0]  m_sch;
  logic [31:0] last_cmd;

  // Recorded DUT activity used by the hand-computed checks.
  logic [31:0] starts_rec[$];
  int          start_cyc[$];
  int          sample_cyc[$];
  int          sample_ch[$];
  bit          sample_fs[$];
  int          dut_starts = 0;
  int          last_done_cyc = 0;
  int          busy_fall_cyc = 0;

  function automatic logic [31:0] cmd_of(input int k);
    if (k == 0) return CMD_CAL;
    if (k <= CAL_DUMMIES) return CMD_DUMMY;
    return {2'b00, 6'((k - 1 - CAL_DUMMIES) % NUM_CH), 24'h000000};
  endfunction

  task automatic model_reset();
    m_st = M_IDLE; pending = 0; idx = 0; cur_k = 0; last_cmd = '0;
    m_prev_en = 1; m_ovr = 0; m_sv = 0; m_fs = 0; m_sdata = '0; m_sch = '0;
    force_lat = 0; prev_busy = 0;
  endtask

  // One clock cycle: drive slave inputs, compare at the falling edge, advance the model.
  task automatic cycle();
    bit          done_now, exp_start, ovr_set, nsv, nfs, pend_before;
    logic [31:0] rx, exp_cmd;
    logic [15:0] nsdata;
    logic [5:0]  nsch;
    int          lat, kk;
    done_now = pending && (cyc == done_at);
    rx = $urandom;
    nsv = 0; nfs = 0; nsdata = '0; nsch = '0;
    if (done_now && cur_k >= 2 && (cur_k - 2) > CAL_DUMMIES) begin
      kk = (cur_k - 2 - 1 - CAL_DUMMIES) % NUM_CH;
      rx[31:16] = {6'(kk), 10'($urandom)};
      nsv = 1; nsch = 6'(kk); nsdata = rx[31:16]; nfs = (kk == 0);
    end
    spi_done_i = done_now;
    spi_rx_i   = rx;
    exp_start = 0; ovr_set = 0;
    if (m_st == M_RUN && enable_i && ((cyc - t0) % DIV) == 0) begin
      if (pending && !done_now) ovr_set = 1;
      else exp_start = 1;
    end
    exp_cmd = exp_start ? cmd_of(idx) : last_cmd;

    @(negedge clk);
    check("spi_start", spi_start_o, exp_start);
    check("spi_data_in", spi_data_in_o, exp_cmd);
    check("busy", busy_o, m_st != M_IDLE);
    check("overrun", overrun_o, m_ovr);
    check("sample_valid", sample_valid_o, m_sv);
    check("frame_start", frame_start_o, m_fs);
    if (m_sv) begin
      check("sample_data", sample_data_o, m_sdata);
      check("sample_channel", sample_channel_o, m_sch);
    end
    if (spi_start_o) begin
      dut_starts++;
      starts_rec.push_back(spi_data_in_o);
      start_cyc.push_back(cyc);
    end
    if (sample_valid_o) begin
      sample_cyc.push_back(cyc);
      sample_ch.push_back(int'(sample_channel_o));
      sample_fs.push_back(frame_start_o);
    end
    if (prev_busy && !busy_o) busy_fall_cyc = cyc;
    prev_busy = busy_o;

    pend_before = pending;
    if (done_now) begin
      pending = 0;
      last_done_cyc = cyc;
    end
    if (exp_start) begin
      lat = (force_lat > 0) ? force_lat : int'($urandom_range(lat_hi, lat_lo));
      force_lat = 0;
      pending = 1; cur_k = idx; done_at = cyc + lat;
      last_cmd = exp_cmd; idx++;
    end
    m_sv = nsv; m_fs = nfs; m_sdata = nsdata; m_sch = nsch;
    if (ovr_set) m_ovr = 1;
    case (m_st)
      M_IDLE:  if (enable_i && !m_prev_en) begin m_st = M_RUN; t0 = cyc + 1; idx = 0; m_ovr = 0; end
      M_RUN:   if (!enable_i) m_st = M_DRAIN;
      default: if (!pend_before || done_now) m_st = M_IDLE;
    endcase
    m_prev_en = enable_i;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic run_until_idx(input int n);
    int guard;
    guard = 0;
    while (idx < n && guard < 4 * DIV * (n + 2)) begin
      cycle();
      guard++;
    end
    if (idx < n) check("timeout_waiting_for_start", idx, n);
  endtask

  task automatic run_until_idle();
    int guard;
    guard = 0;
    while (m_st != M_IDLE && guard < 3 * DIV) begin
      cycle();
      guard++;
    end
    if (m_st != M_IDLE) check("timeout_waiting_for_idle", 1, 0);
  endtask

  task automatic check_all_zero(input string name);
    check(name, {spi_start_o, spi_data_in_o, sample_valid_o, sample_data_o,
                 sample_channel_o, frame_start_o, overrun_o, busy_o}, 64'h0);
  endtask

  initial begin
    int cs, cn, saved, chain_ok;
    model_reset();
    lat_lo = 60; lat_hi = 60;
    #2;
    check_all_zero("reset_outputs");
    @(posedge clk);
    #1;
    rst = 1'b0;
    run(5);

    // Session A: fixed latency, then done-on-due, then one overrun, then random.
    enable_i = 1'b1;
    run_until_idx(19);
    run(DIV);
    check("start0_calibrate", starts_rec[0], 32'h5500_0000);
    for (int i = 1; i <= 9; i++) check("start_dummy", starts_rec[i], 32'hFF00_0000);
    check("start10_conv", starts_rec[10], 32'h0000_0000);
    check("start11_conv", starts_rec[11], 32'h0100_0000);
    check("start12_conv", starts_rec[12], 32'h0200_0000);
    check("start13_conv", starts_rec[13], 32'h0300_0000);
    check("start14_conv", starts_rec[14], 32'h0000_0000);
    check("start_spacing", start_cyc[1] - start_cyc[0], DIV);
    check("first_sample_time", sample_cyc[0], start_cyc[12] + 61);
    check("first_sample_channel", sample_ch[0], 0);
    check("first_sample_frame", sample_fs[0], 1);
    check("sample_spacing", sample_cyc[1] - sample_cyc[0], DIV);
    check("sample1_channel", sample_ch[1], 1);
    check("sample3_channel", sample_ch[3], 3);
    check("sample4_channel", sample_ch[4], 0);

    lat_lo = DIV; lat_hi = DIV;
    run_until_idx(24);
    check("no_overrun_done_on_due", overrun_o, 0);

    lat_lo = 30; lat_hi = DIV;
    force_lat = DIV + 20;
    run_until_idx(idx + 1);
    cs = start_cyc[start_cyc.size() - 1];
    run_until_idx(idx + 1);
    cn = start_cyc[start_cyc.size() - 1];
    check("overrun_skips_one_slot", cn - cs, 2 * DIV);
    check("overrun_sticky", overrun_o, 1);
    run_until_idx(34);
    chain_ok = 1;
    for (int i = 0; i + 1 < sample_ch.size(); i++)
      if (sample_ch[i + 1] != (sample_ch[i] + 1) % NUM_CH) chain_ok = 0;
    check("channel_sequence_gapless", chain_ok, 1);

    // Drop enable right after a start: the outstanding result drains, then idle.
    lat_lo = 60; lat_hi = 60;
    run_until_idx(idx + 1);
    enable_i = 1'b0;
    saved = dut_starts;
    run_until_idle();
    run(4);
    check("no_start_after_disable", dut_starts, saved);
    check("busy_falls_after_last_done", busy_fall_cyc - last_done_cyc, 1);

    // Re-enable: calibrate comes first and overrun clears.
    enable_i = 1'b1;
    run(2);
    check("reenable_calibrate", starts_rec[starts_rec.size() - 1], 32'h5500_0000);
    check("reenable_overrun_clear", overrun_o, 0);
    run_until_idx(6);
    run(10);

    // Asynchronous reset between edges while a transaction is outstanding.
    #2;
    rst = 1'b1;
    spi_done_i = 1'b0;
    #1;
    check_all_zero("async_reset_outputs");
    @(posedge clk); #1; cyc++;
    @(posedge clk); #1; cyc++;
    rst = 1'b0;
    model_reset();
    saved = dut_starts;
    run(300);
    check("idle_after_reset_no_start", dut_starts, saved);
    check("idle_after_reset_busy", busy_o, 0);

    // Session C: fully random latencies.
    lat_lo = 30; lat_hi = DIV;
    enable_i = 1'b0;
    run(1);
    enable_i = 1'b1;
    run_until_idx(30);
    enable_i = 1'b0;
    run_until_idle();
    run(5);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
